// File: rtl/div_array_io_stage.sv
// Handshaked front/back stage for the combinational 16/8 array divider.
// Screens divide-by-zero and quotient overflow so the array only sees in-range operands.
module div_array_io_stage #(
    parameter int N_W           = 16,
    parameter int D_W           = 8,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N_W-1:0] in_n,
    input  logic [D_W-1:0] in_d,
    output logic [N_W-1:0] arr_n,
    output logic [D_W-1:0] arr_d,
    input  logic [D_W-1:0] arr_q,
    input  logic [D_W-1:0] arr_r,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [D_W-1:0] out_q,
    output logic [D_W-1:0] out_r,
    output logic           out_dz,
    output logic           out_ovf,
    output logic [15:0]    cnt_ok,
    output logic [15:0]    cnt_err
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_HOLD   = 2'd2;

    logic [1:0]     state_q, state_d;
    logic [3:0]     settle_q, settle_d;
    logic [N_W-1:0] arr_n_q, arr_n_d;
    logic [D_W-1:0] arr_d_q, arr_d_d;
    logic [D_W-1:0] res_q_q, res_q_d;
    logic [D_W-1:0] res_r_q, res_r_d;
    logic           dz_q, dz_d;
    logic           ovf_q, ovf_d;
    logic [15:0]    cnt_ok_q, cnt_ok_d;
    logic [15:0]    cnt_err_q, cnt_err_d;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_comb begin
        state_d   = state_q;
        settle_d  = settle_q;
        arr_n_d   = arr_n_q;
        arr_d_d   = arr_d_q;
        res_q_d   = res_q_q;
        res_r_d   = res_r_q;
        dz_d      = dz_q;
        ovf_d     = ovf_q;
        cnt_ok_d  = cnt_ok_q;
        cnt_err_d = cnt_err_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (in_d == '0) begin
                        res_q_d = '1;
                        res_r_d = in_n[D_W-1:0];
                        dz_d    = 1'b1;
                        ovf_d   = 1'b0;
                        state_d = S_HOLD;
                    end else if (in_n[N_W-1:D_W] >= in_d) begin
                        // Quotient would not fit in D_W bits; the array is kept idle
                        res_q_d = '1;
                        res_r_d = '0;
                        dz_d    = 1'b0;
                        ovf_d   = 1'b1;
                        state_d = S_HOLD;
                    end else begin
                        arr_n_d  = in_n;
                        arr_d_d  = in_d;
                        settle_d = 4'(SETTLE_CYCLES - 1);
                        state_d  = S_SETTLE;
                    end
                end
            end
            S_SETTLE: begin
                if (settle_q == 4'd0) begin
                    res_q_d = arr_q;
                    res_r_d = arr_r;
                    dz_d    = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = S_HOLD;
                end else begin
                    settle_d = settle_q - 4'd1;
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    if (dz_q | ovf_q) cnt_err_d = sat_inc(cnt_err_q);
                    else              cnt_ok_d  = sat_inc(cnt_ok_q);
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            settle_q  <= '0;
            arr_n_q   <= '0;
            arr_d_q   <= '0;
            res_q_q   <= '0;
            res_r_q   <= '0;
            dz_q      <= 1'b0;
            ovf_q     <= 1'b0;
            cnt_ok_q  <= '0;
            cnt_err_q <= '0;
        end else begin
            state_q   <= state_d;
            settle_q  <= settle_d;
            arr_n_q   <= arr_n_d;
            arr_d_q   <= arr_d_d;
            res_q_q   <= res_q_d;
            res_r_q   <= res_r_d;
            dz_q      <= dz_d;
            ovf_q     <= ovf_d;
            cnt_ok_q  <= cnt_ok_d;
            cnt_err_q <= cnt_err_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_HOLD);
    assign arr_n     = arr_n_q;
    assign arr_d     = arr_d_q;
    assign out_q     = res_q_q;
    assign out_r     = res_r_q;
    assign out_dz    = dz_q;
    assign out_ovf   = ovf_q;
    assign cnt_ok    = cnt_ok_q;
    assign cnt_err   = cnt_err_q;

endmodule

// File: tb/tb_div_array_io_stage.sv
// Directed bench for div_array_io_stage with an exact array divider model.
module tb_div_array_io_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_n;
    logic [7:0]  in_d;
    logic [15:0] arr_n;
    logic [7:0]  arr_d;
    logic [7:0]  arr_q;
    logic [7:0]  arr_r;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_q;
    logic [7:0]  out_r;
    logic        out_dz;
    logic        out_ovf;
    logic [15:0] cnt_ok;
    logic [15:0] cnt_err;

    int checks   = 0;
    int failures = 0;

    div_array_io_stage #(.N_W(16), .D_W(8), .SETTLE_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_n(in_n), .in_d(in_d),
        .arr_n(arr_n), .arr_d(arr_d), .arr_q(arr_q), .arr_r(arr_r),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_q(out_q), .out_r(out_r), .out_dz(out_dz), .out_ovf(out_ovf),
        .cnt_ok(cnt_ok), .cnt_err(cnt_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Exact combinational array divider
    logic [15:0] quo_m, rem_m;
    always_comb begin
        quo_m = '0;
        rem_m = '0;
        if (arr_d != 8'd0) begin
            quo_m = arr_n / {8'd0, arr_d};
            rem_m = arr_n % {8'd0, arr_d};
        end
        arr_q = quo_m[7:0];
        arr_r = rem_m[7:0];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [15:0] n, input logic [7:0] d);
        in_n     = n;
        in_d     = d;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_n      = '0;
        in_d      = '0;
        #3;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_q", out_q, 0);
        check("rst_out_r", out_r, 0);
        check("rst_flags", {out_dz, out_ovf}, 0);
        check("rst_arr", {arr_n, arr_d}, 0);
        check("rst_cnts", {cnt_ok, cnt_err}, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Clean divide 100/7
        send(16'h0064, 8'h07);
        check("clean1_in_ready", in_ready, 0);
        check("clean1_arr_n", arr_n, 16'h0064);
        check("clean1_arr_d", arr_d, 8'h07);
        check("clean1_valid_e1", out_valid, 0);
        tick();
        check("clean1_valid_e2", out_valid, 0);
        tick();
        check("clean1_valid_e3", out_valid, 1);
        check("clean1_q", out_q, 8'h0E);
        check("clean1_r", out_r, 8'h02);
        check("clean1_flags", {out_dz, out_ovf}, 0);
        handshake();
        check("clean1_cnt_ok", cnt_ok, 1);
        check("clean1_cnt_err", cnt_err, 0);
        check("clean1_idle", in_ready, 1);
        check("clean1_valid_low", out_valid, 0);

        // Divide-by-zero, then backpressure in HOLD
        send(16'h1234, 8'h00);
        check("dz_valid", out_valid, 1);
        check("dz_q", out_q, 8'hFF);
        check("dz_r", out_r, 8'h34);
        check("dz_flags", {out_dz, out_ovf}, 2'b10);
        check("dz_arr_quiet", {arr_n, arr_d}, {16'h0064, 8'h07});
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0];
            in_n     = 16'h0011;
            in_d     = 8'h03;
            tick();
            check("bp_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
            check("bp_data", {out_q, out_r, out_dz, out_ovf}, {8'hFF, 8'h34, 2'b10});
            check("bp_arr", {arr_n, arr_d}, {16'h0064, 8'h07});
            check("bp_cnts", {cnt_ok, cnt_err}, {16'd1, 16'd0});
        end
        in_valid = 1'b0;
        handshake();
        check("dz_cnt_err", cnt_err, 1);
        check("dz_cnt_ok", cnt_ok, 1);
        check("dz_idle", in_ready, 1);
        tick();
        check("dz_cnt_err_once", cnt_err, 1);

        // Overflow boundary: upper byte equal to divisor
        send(16'h0A00, 8'h0A);
        check("ovf_valid", out_valid, 1);
        check("ovf_q", out_q, 8'hFF);
        check("ovf_r", out_r, 8'h00);
        check("ovf_flags", {out_dz, out_ovf}, 2'b01);
        check("ovf_arr_quiet", {arr_n, arr_d}, {16'h0064, 8'h07});
        handshake();
        check("ovf_cnt_err", cnt_err, 2);

        // dz wins over ovf when both apply
        send(16'hFF00, 8'h00);
        check("prio_flags", {out_dz, out_ovf}, 2'b10);
        check("prio_r", out_r, 8'h00);
        handshake();
        check("prio_cnt_err", cnt_err, 3);

        // Largest clean quotient: 2559/10
        send(16'h09FF, 8'h0A);
        check("edge_arr_n", arr_n, 16'h09FF);
        tick();
        tick();
        check("edge_valid", out_valid, 1);
        check("edge_q", out_q, 8'hFF);
        check("edge_r", out_r, 8'h09);
        check("edge_flags", {out_dz, out_ovf}, 0);
        handshake();
        check("edge_cnt_ok", cnt_ok, 2);

        // Reset asserted one cycle after a clean accept
        send(16'h0100, 8'h03);
        tick();
        rst_n = 1'b0;
        #1;
        check("mrst_out_valid", out_valid, 0);
        check("mrst_in_ready", in_ready, 1);
        check("mrst_arr", {arr_n, arr_d}, 0);
        check("mrst_out", {out_q, out_r, out_dz, out_ovf}, 0);
        check("mrst_cnts", {cnt_ok, cnt_err}, 0);
        tick();
        rst_n = 1'b1;
        tick();
        send(16'h00FF, 8'h10);
        tick();
        tick();
        check("post_rst_valid", out_valid, 1);
        check("post_rst_q", out_q, 8'h0F);
        check("post_rst_r", out_r, 8'h0F);
        handshake();
        check("post_rst_cnt_ok", cnt_ok, 1);

        // Saturation of cnt_ok
        force dut.cnt_ok_q = 16'hFFFE;
        #1;
        release dut.cnt_ok_q;
        for (int i = 0; i < 3; i++) begin
            send(16'h0050, 8'h05);
            tick();
            tick();
            check("sat_q", out_q, 8'h10);
            handshake();
            check("sat_cnt_ok", cnt_ok, 16'hFFFF);
        end
        check("sat_cnt_err", cnt_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/div_array_io_stage.md
Name: div_array_io_stage

Overview:
- Sequential front/back stage wrapped around the combinational 16/8 array divider (exact or approximate variant).
- Accepts a dividend/divisor pair on a valid/ready handshake and drives the array inputs stable for a settle window.
- Captures the array's quotient and remainder, then presents the result on a valid/ready handshake.
- Screens divide-by-zero and quotient-overflow operands so the array never sees out-of-range inputs; keeps saturating transaction and error counters.

Parameters:
- N_W, 16, dividend width; must equal 2*D_W.
- D_W, 8, divisor/quotient/remainder width.
- SETTLE_CYCLES, 2, cycles arr_n/arr_d are held before arr_q/arr_r are sampled; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  stage can accept operands.
- in_n  in  N_W  dividend.
- in_d  in  D_W  divisor.
- arr_n  out  N_W  dividend driven to array.
- arr_d  out  D_W  divisor driven to array.
- arr_q  in  D_W  quotient from array.
- arr_r  in  D_W  remainder from array.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_q  out  D_W  quotient.
- out_r  out  D_W  remainder.
- out_dz  out  1  result flagged divide-by-zero.
- out_ovf  out  1  result flagged quotient overflow.
- cnt_ok  out  16  count of clean results delivered, saturating.
- cnt_err  out  16  count of dz/ovf results delivered, saturating.

Behaviour:
- Reset values (async assert, sync deassert on next edge): state=IDLE, in_ready=1, out_valid=0, out_q=0, out_r=0, out_dz=0, out_ovf=0, arr_n=0, arr_d=0, cnt_ok=0, cnt_err=0, settle counter=0.
- States: IDLE, SETTLE, HOLD.
- IDLE: in_ready=1. On in_valid&in_ready, classify the operands:
  - in_d==0: out_q=all ones, out_r=in_n[D_W-1:0], out_dz=1, out_ovf=0 -> HOLD. arr_n/arr_d unchanged.
  - else in_n[N_W-1:D_W] >= in_d: out_q=all ones, out_r=0, out_ovf=1, out_dz=0 -> HOLD. arr_n/arr_d unchanged.
  - else: register arr_n=in_n, arr_d=in_d, settle counter=SETTLE_CYCLES-1 -> SETTLE.
  - dz takes priority over ovf; the two flags are never both 1.
- SETTLE: in_ready=0; arr_n/arr_d held.
  - Counter decrements each cycle.
  - In the cycle the counter is 0: out_q=arr_q, out_r=arr_r, out_dz=0, out_ovf=0 -> HOLD.
  - Clean-path latency from the accept edge to out_valid=1 is SETTLE_CYCLES+1 cycles.
  - Error-path latency is 1 cycle.
- HOLD: out_valid=1, in_ready=0.
  - out_q, out_r and flags stay stable until out_ready.
  - On out_valid&out_ready: cnt_err+=1 if out_dz|out_ovf, else cnt_ok+=1 -> IDLE.
  - No back-to-back bypass: a new operand is accepted no earlier than the cycle after the handshake (IDLE cycle).
- in_valid is ignored outside IDLE. Input data is sampled only on the accept edge.
- Counters saturate at 16'hFFFF and never wrap.
- Counters and output data registers are not cleared by a return to IDLE, only by reset.
- Reset asserted mid-SETTLE or mid-HOLD: the in-flight result is discarded, all outputs return to reset values immediately, no counter increment.
- arr_n/arr_d change only on a clean accept. The array inputs therefore stay quiet through error transactions (power requirement).

Test Plan:
- Clean divide, SETTLE_CYCLES=2, bench array model exact: in_n=16'h0064, in_d=8'h07 -> out_valid 3 cycles after accept, out_q=8'h0E, out_r=8'h02, flags 0, cnt_ok=1.
- Divide-by-zero: in_n=16'h1234, in_d=0 -> out_valid 1 cycle after accept, out_q=8'hFF, out_r=8'h34, out_dz=1, arr_n/arr_d unchanged, cnt_err=1.
- Overflow: in_n=16'h0A00, in_d=8'h0A -> out_q=8'hFF, out_r=0, out_ovf=1. Also in_n=16'h09FF, in_d=8'h0A -> clean, out_q=8'hFF, out_r=8'h09.
- Backpressure: out_ready low 5 cycles in HOLD -> outputs stable, in_ready=0, in_valid pulses ignored; on out_ready high, one counter increment, IDLE next cycle.
- Reset mid-SETTLE: assert rst_n=0 one cycle after a clean accept -> all outputs 0 immediately, counters 0; the next transaction completes normally.
- Saturation: force 65536 clean transactions (or preload via hierarchical force to 16'hFFFE, then 3 transactions) -> cnt_ok holds at 16'hFFFF.
